// File: rtl/isi_hist_acc_pkg.sv
// isi_hist_acc_pkg: shared FSM state, default widths and counter limit for the ISI histogram
package isi_hist_acc_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int DEF_BIT_ISI = 8;
  localparam int DEF_BIT_CNT = 16;
  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
  localparam logic [31:0] CNT_MAX = cnt_max(DEF_BIT_CNT);
endpackage

// File: rtl/isi_hist_ram.sv
// isi_hist_ram: dual-port RAM, port A sync read plus write, port B sync read, old data on collision
module isi_hist_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_raddr,
  output logic [DW-1:0] b_rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_raddr];
  end
endmodule

// File: rtl/isi_hist_acc.sv
// isi_hist_acc: ISI histogram with pipelined read-modify-write, forwarding, clear sweep and host read port
module isi_hist_acc
  import isi_hist_acc_pkg::*;
#(
  parameter int BIT_ISI = DEF_BIT_ISI,
  parameter int BIT_CNT = DEF_BIT_CNT
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [BIT_ISI-1:0] isi_z,
  input  logic               valid,
  input  logic               clear_req,
  input  logic               rd_req,
  input  logic [BIT_ISI-1:0] rd_addr,
  output logic               rd_ack,
  output logic [BIT_CNT-1:0] rd_data,
  output logic               busy,
  output logic               overflow,
  output logic               dropped
);
  localparam logic [BIT_CNT-1:0] MAX = BIT_CNT'(cnt_max(BIT_CNT));
  state_t state, state_n;
  logic [BIT_ISI-1:0] clr_addr, s1_a, s2_a, s3_a, s4_a, rd_a;
  logic [BIT_CNT-1:0] s3_d, s4_d, ram_a, ram_b, opnd, nxt, wdata;
  logic [BIT_ISI-1:0] waddr;
  logic s1_v, s2_v, s3_v, s4_v, rd_v, run, sat, we_acc, we;
  assign run = state == RUN;
  assign busy = !run;
  always_comb state_n = clear_req ? CLEAR : (!run && &clr_addr) ? RUN : state;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) state <= CLEAR;
    else state <= state_n;
  // S2 operand: newest pending value wins, since the RAM read missed the S3 and S4 writes
  always_comb begin
    opnd = (s3_v && s3_a == s2_a) ? s3_d : (s4_v && s4_a == s2_a) ? s4_d : ram_a;
    sat = opnd == MAX;
    nxt = sat ? opnd : opnd + 1'b1;
    we_acc = run && s3_v && !clear_req;
    we = !run || we_acc;
    waddr = run ? s3_a : clr_addr;
    wdata = run ? s3_d : '0;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      clr_addr <= '0;
      {s1_v, s2_v, s3_v, s4_v, rd_v, rd_ack, overflow, dropped} <= '0;
      {s1_a, s2_a, s3_a, s4_a, rd_a} <= '0;
      {s3_d, s4_d} <= '0;
    end else begin
      clr_addr <= (clear_req || run) ? '0 : clr_addr + 1'b1;
      s1_v <= valid && run && !clear_req;
      s1_a <= isi_z;
      s2_v <= s1_v && !clear_req;
      s2_a <= s1_a;
      s3_v <= s2_v && !clear_req;
      s3_a <= s2_a;
      s3_d <= nxt;
      s4_v <= we_acc;
      s4_a <= s3_a;
      s4_d <= s3_d;
      rd_v <= rd_req && run && !clear_req;
      rd_a <= rd_addr;
      rd_ack <= rd_v && !clear_req;
      overflow <= !clear_req && (overflow || (s2_v && sat));
      dropped <= !clear_req && (dropped || (valid && !run));
    end
  assign rd_data = rd_ack ? ram_b : '0;
  isi_hist_ram #(.AW(BIT_ISI), .DW(BIT_CNT)) u_ram (
    .clk(clk),
    .a_we(we),
    .a_waddr(waddr),
    .a_wdata(wdata),
    .a_raddr(s1_a),
    .a_rdata(ram_a),
    .b_raddr(rd_a),
    .b_rdata(ram_b)
  );
endmodule
